// File: rtl/drug_pump_actuator.sv
// drug_pump_actuator: turns a latched dosage into a timed train of pump step pulses,
// with CPR abort, post-delivery lockout and progress/completion reporting.
// Optional macro DOSE_LOG_EN adds total_units, a saturating count of units delivered since reset.
module drug_pump_actuator #(
  parameter int unsigned PULSES_PER_UNIT = 8,
  parameter int unsigned PULSE_HI        = 4,
  parameter int unsigned PULSE_LO        = 12,
  parameter int unsigned LOCKOUT_CYCLES  = 1000,
  parameter int unsigned MAX_DOSE        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drug_delivery_activate,
  input  logic [3:0]  drug_dosage,
  input  logic        cpr_activate,
  output logic        pump_step,
  output logic        busy,
  output logic        lockout,
  output logic [3:0]  delivered_units,
  output logic        dose_done,
`ifdef DOSE_LOG_EN
  output logic        aborted,
  output logic [15:0] total_units
`else
  output logic        aborted
`endif
);

  typedef enum logic [1:0] {IDLE, STEP_HI, STEP_LO, LOCKOUT} state_t;

  // One phase counter serves the high, low and lockout intervals.
  localparam int unsigned HL_MAX  = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int unsigned CNT_MAX = (HL_MAX > LOCKOUT_CYCLES) ? HL_MAX : LOCKOUT_CYCLES;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  localparam logic [11:0] PPU_W   = 12'(PULSES_PER_UNIT);

  state_t        state, state_nx;
  logic [CW-1:0] phase, phase_nx;
  logic [11:0]   pulse_cnt, pulse_nx;   // 15*255 pulses fit without wrap
  logic [7:0]    unit_sub, unit_sub_nx; // pulses into the current unit
  logic [3:0]    dose, dose_nx;
  logic [3:0]    units_nx;
  logic          done_nx, abort_nx;
  logic          act_hist;
  logic          req;
  logic [11:0]   target;

  assign req     = drug_delivery_activate & ~act_hist;
  assign target  = {8'd0, dose} * PPU_W;
  assign busy    = (state == STEP_HI) || (state == STEP_LO);
  assign lockout = (state == LOCKOUT);

  // Next-state and datapath decisions; an abort beats a pulse completing on the same edge.
  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    pulse_nx    = pulse_cnt;
    unit_sub_nx = unit_sub;
    dose_nx     = dose;
    units_nx    = delivered_units;
    done_nx     = 1'b0;
    abort_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !cpr_activate && (drug_dosage != 4'd0)) begin
          state_nx    = STEP_HI;
          phase_nx    = '0;
          pulse_nx    = '0;
          unit_sub_nx = '0;
          dose_nx     = (drug_dosage > 4'(MAX_DOSE)) ? 4'(MAX_DOSE) : drug_dosage;
          units_nx    = '0;
        end
      end
      STEP_HI: begin
        if (cpr_activate) begin
          state_nx = LOCKOUT;
          phase_nx = '0;
          abort_nx = 1'b1;
        end else if (phase == CW'(PULSE_HI - 1)) begin
          state_nx = STEP_LO;
          phase_nx = '0;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      STEP_LO: begin
        if (cpr_activate) begin
          state_nx = LOCKOUT;
          phase_nx = '0;
          abort_nx = 1'b1;
        end else if (phase == CW'(PULSE_LO - 1)) begin
          phase_nx = '0;
          pulse_nx = pulse_cnt + 12'd1;
          if (unit_sub == 8'(PULSES_PER_UNIT - 1)) begin
            unit_sub_nx = '0;
            units_nx    = delivered_units + 4'd1;
          end else begin
            unit_sub_nx = unit_sub + 8'd1;
          end
          if (pulse_nx == target) begin
            state_nx = LOCKOUT;
            done_nx  = 1'b1;
          end else begin
            state_nx = STEP_HI;
          end
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      LOCKOUT: begin
        if (phase == CW'(LOCKOUT_CYCLES - 1)) begin
          state_nx = IDLE;
          phase_nx = '0;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs; history resets high so a held level is not a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      phase           <= '0;
      pulse_cnt       <= '0;
      unit_sub        <= '0;
      dose            <= '0;
      delivered_units <= '0;
      dose_done       <= 1'b0;
      aborted         <= 1'b0;
      pump_step       <= 1'b0;
      act_hist        <= 1'b1;
    end else begin
      state           <= state_nx;
      phase           <= phase_nx;
      pulse_cnt       <= pulse_nx;
      unit_sub        <= unit_sub_nx;
      dose            <= dose_nx;
      delivered_units <= units_nx;
      dose_done       <= done_nx;
      aborted         <= abort_nx;
      pump_step       <= (state_nx == STEP_HI);
      act_hist        <= drug_delivery_activate;
    end
  end

`ifdef DOSE_LOG_EN
  // Cumulative unit log: follows each unit increment (5-bit compare so a restart from 15 is not counted).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_units <= '0;
    end else if (({1'b0, units_nx} == ({1'b0, delivered_units} + 5'd1)) && (total_units != 16'hFFFF)) begin
      total_units <= total_units + 16'd1;
    end
  end
`endif

endmodule
